// File: rtl/tdm_demux.sv
// tdm_demux: serial-to-parallel TDM demultiplexer with double-buffered output.
// Optional parity beat per frame enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int WIDTH = 16,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [SELW-1:0]  ch_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_perr,
  output logic             sync_err
);

  localparam logic [SELW-1:0] LAST = SELW'(WIDTH - 1);

  logic [SELW-1:0]  idx;
  logic [SELW-1:0]  idx_nxt;
  logic [WIDTH-1:0] asm_data;
  logic [WIDTH-1:0] asm_nxt;
  logic             asm_full;
  logic             asm_perr;
  logic             par_phase;
  logic             par_nxt;
  logic             accept;
  logic             slot_free;
  logic             done;
  logic             done_perr;
  logic             mid_sync;

  assign in_ready  = !asm_full;
  assign ch_sel    = idx;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    asm_nxt   = asm_data;
    idx_nxt   = idx;
    par_nxt   = par_phase;
    done      = 1'b0;
    done_perr = 1'b0;
    mid_sync  = 1'b0;
    if (accept) begin
      if (in_sync) begin
        // Sync restarts the frame; any partial frame is dropped.
        asm_nxt[0] = in_bit;
        idx_nxt    = SELW'(1);
        par_nxt    = 1'b0;
        mid_sync   = (idx != '0) || par_phase;
      end else if (par_phase) begin
        done      = 1'b1;
        par_nxt   = 1'b0;
        idx_nxt   = '0;
`ifdef TDM_DEMUX_PARITY_EN
        done_perr = (^asm_data) ^ in_bit;
`endif
      end else begin
        asm_nxt[idx] = in_bit;
        if (idx == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
          par_nxt = 1'b1;
`else
          done    = 1'b1;
          idx_nxt = '0;
`endif
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      asm_data  <= '0;
      asm_full  <= 1'b0;
      asm_perr  <= 1'b0;
      par_phase <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      par_phase <= par_nxt;
      asm_data  <= asm_nxt;
      if (mid_sync)
        sync_err <= 1'b1;
      if (asm_full && slot_free) begin
        out_data  <= asm_data;
        out_perr  <= asm_perr;
        out_valid <= 1'b1;
        asm_full  <= 1'b0;
      end else if (done && slot_free) begin
        out_data  <= asm_nxt;
        out_perr  <= done_perr;
        out_valid <= 1'b1;
      end else if (done) begin
        // Output slot busy: park the frame in the assembly register.
        asm_full <= 1'b1;
        asm_perr <= done_perr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed checks of tdm_demux at WIDTH 4, 8 and 16.
// Shared stimulus drives all three instances; each test checks one.
module tb_tdm_demux;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic in_sync;
  logic out_ready;

  logic        rdy8, ov8, pe8, se8;
  logic [2:0]  cs8;
  logic [7:0]  od8;
  logic        rdy16, ov16, pe16, se16;
  logic [3:0]  cs16;
  logic [15:0] od16;
  logic        rdy4, ov4, pe4, se4;
  logic [1:0]  cs4;
  logic [3:0]  od4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_sync(in_sync), .in_ready(rdy8), .ch_sel(cs8),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
    .out_perr(pe8), .sync_err(se8));

  tdm_demux #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_sync(in_sync), .in_ready(rdy16), .ch_sel(cs16),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16),
    .out_perr(pe16), .sync_err(se16));

  tdm_demux #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_sync(in_sync), .in_ready(rdy4), .ch_sel(cs4),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .out_perr(pe4), .sync_err(se4));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_sync  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic b, input logic s);
    in_valid = 1'b1;
    in_bit   = b;
    in_sync  = s;
    tick();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int n, input logic s);
    logic [15:0] v;
    v = w;
    for (int i = 0; i < n; i++)
      beat(v[i], s && (i == 0));
  endtask

  task automatic chk_reset8();
    chk("rst_ov", ov8, 0);
    chk("rst_od", od8, 0);
    chk("rst_pe", pe8, 0);
    chk("rst_se", se8, 0);
    chk("rst_cs", cs8, 0);
    chk("rst_rdy", rdy8, 1);
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();
    chk_reset8();

`ifdef TDM_DEMUX_PARITY_EN
    send(16'h00A5, 8, 1'b0);
    chk("par_cs7", cs8, 7);
    chk("par_nov", ov8, 0);
    beat(1'b0, 1'b0);
    chk("par0_ov", ov8, 1);
    chk("par0_od", od8, 8'hA5);
    chk("par0_pe", pe8, 0);
    chk("par0_cs", cs8, 0);
    send(16'h00A5, 8, 1'b0);
    beat(1'b1, 1'b0);
    chk("par1_ov", ov8, 1);
    chk("par1_od", od8, 8'hA5);
    chk("par1_pe", pe8, 1);
    tick();
    chk("par1_drop", ov8, 0);
`else
    // 0,1,0,1,... LSB first gives 8'hAA
    for (int i = 0; i < 8; i++) begin
      chk("aa_cs", cs8, i);
      chk("aa_nov", ov8, 0);
      beat(i[0], 1'b0);
    end
    chk("aa_ov", ov8, 1);
    chk("aa_od", od8, 8'hAA);
    chk("aa_cs0", cs8, 0);
    chk("aa_pe", pe8, 0);
    tick();
    chk("aa_drop", ov8, 0);

    do_reset();
    out_ready = 1'b0;
    send(16'h003C, 8, 1'b0);
    chk("bp1_ov", ov8, 1);
    chk("bp1_od", od8, 8'h3C);
    chk("bp1_rdy", rdy8, 1);
    send(16'h00C3, 8, 1'b0);
    chk("bp2_rdy", rdy8, 0);
    chk("bp2_od", od8, 8'h3C);
    tick();
    chk("bp2_hold", od8, 8'h3C);
    chk("bp2_ov", ov8, 1);
    out_ready = 1'b1;
    tick();
    chk("bp3_od", od8, 8'hC3);
    chk("bp3_ov", ov8, 1);
    chk("bp3_rdy", rdy8, 1);
    tick();
    chk("bp3_drop", ov8, 0);

    do_reset();
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    chk("sy_pre", se16, 0);
    beat(1'b0, 1'b1);
    chk("sy_err", se16, 1);
    chk("sy_cs", cs16, 1);
    chk("sy_nov", ov16, 0);
    send(16'h1234 >> 1, 15, 1'b0);
    chk("sy_ov", ov16, 1);
    chk("sy_od", od16, 16'h1234);
    send(16'hBEEF, 16, 1'b0);
    chk("sy_od2", od16, 16'hBEEF);
    chk("sy_stick", se16, 1);

    do_reset();
    send(16'h00FF, 5, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset8();
    rst = 1'b0;
    send(16'h000F, 8, 1'b0);
    chk("r_ov", ov8, 1);
    chk("r_od", od8, 8'h0F);

    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) begin
        beat((f == i), 1'b0);
        chk("st_rdy", rdy4, 1);
        chk("st_ov", ov4, (i == 3));
        if (i == 3)
          chk("st_od", od4, (4'h1 << f));
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Serial-to-parallel time-division demultiplexer: the receiving end of the mux_8to1/mux_16to1 channel-select scheme. One bit per accepted beat is steered into word position `ch_sel`, and a completed frame is presented as a parallel word. Double buffering (assembly register plus output register) lets a new frame fill while the previous word waits downstream. Sits between a serial link and the parallel datapath.

## Interface
- `WIDTH`, 16: channels (data bits) per frame; legal values 2, 4, 8, 16.
- `SELW`, $clog2(WIDTH): width of `ch_sel`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_bit` valid this cycle.
- `in_bit` in 1: serial data bit.
- `in_sync` in 1: qualified by `in_valid`; marks the current bit as channel 0.
- `in_ready` out 1: block accepts a beat this cycle.
- `ch_sel` out SELW: channel index the next accepted data bit is written to.
- `out_valid` out 1: `out_data` holds a complete frame.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_data` out WIDTH: assembled word; bit i = channel i.
- `out_perr` out 1: parity error for `out_data`; 0 unless `TDM_DEMUX_PARITY_EN`.
- `sync_err` out 1: sticky; `in_sync` seen mid-frame.

## Operation
- Beat accepted when `in_valid && in_ready`. Unaccepted beats have no effect.
- Write index `idx` starts at 0. An accepted data beat writes `in_bit` into `asm[idx]`, then `idx` increments.
- Bits arrive channel 0 first (LSB first).
- The accepted beat at `idx == WIDTH-1` completes the frame (see Configuration for the parity beat). `idx` wraps to 0.
- On frame completion, the frame moves to `out_data`, `out_valid` is set, and `out_perr` is updated, all at the same edge, if the output slot is free. The slot is free when `out_valid == 0` or `out_ready == 1`.
- If the slot is not free, the frame is held in `asm` and `asm_full` is set.
- `in_ready = !asm_full` (combinational).
- While `asm_full`: the frame transfers on the first edge where the slot is free, and `asm_full` clears at that edge.
- `out_valid` clears on `out_valid && out_ready` unless a new frame loads at the same edge. A simultaneous drain and load keeps `out_valid` at 1 with the new data.
- `in_sync`, on an accepted beat:
  - The bit is written to `asm[0]` and `idx` becomes 1.
  - If `idx != 0` before the beat, the partial frame is discarded (never output) and `sync_err` is set.
  - `in_sync` at `idx == 0` is legal and silent.
  - With WIDTH == 2 (no parity), a sync beat still requires a second beat to complete the frame.
- `sync_err` clears only on reset.
- `ch_sel = idx` (during the parity beat: WIDTH-1).

## Timing
- Reset values: `idx` 0, `asm` 0, `asm_full` 0, `out_data` 0, `out_valid` 0, `out_perr` 0, `sync_err` 0, `ch_sel` 0, `in_ready` 1.
- Reset mid-frame discards the partial frame and any pending or held word.
- Latency: last beat accepted at edge N gives `out_valid` high after edge N when the slot is free. Back-to-back frames stream at 1 bit per cycle with no bubbles while `out_ready == 1`.
- Backpressure: at most one full frame is buffered in `asm`. `in_ready` drops the cycle after the frame completes into a busy slot.
- `out_data` and `out_perr` are stable while `out_valid && !out_ready`.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - A frame is WIDTH data beats plus one even-parity beat.
  - On the parity beat, `idx` holds WIDTH-1 internally and a `par_phase` flag is set.
  - `out_perr = ^data ^ parity_bit`.
  - `in_sync` on the parity beat counts as a mid-frame sync.
- Not defined: frame is WIDTH beats and `out_perr` is tied to 0.

## Test plan
- WIDTH=8, `out_ready`=1: beats 0,1,0,1,0,1,0,1 -> `out_data`=8'hAA, `out_valid` for one cycle the edge after the 8th beat; `ch_sel` counts 0..7 and wraps to 0.
- WIDTH=8, `out_ready`=0: send 8'h3C then 8'hC3 -> after the 2nd frame `in_ready`=0 and `out_data` holds 8'h3C. Raise `out_ready` -> 8'h3C consumed, 8'hC3 appears the next cycle, `in_ready` returns to 1.
- WIDTH=16: 3 beats, then `in_sync` beat starting 16'h1234 -> only 16'h1234 is output and `sync_err`=1. It stays 1 across subsequent frames.
- Assert `rst` after 5 beats of a WIDTH=8 frame, then send 8'h0F -> `out_data`=8'h0F, and all outputs equal their reset values during reset.
- `TDM_DEMUX_PARITY_EN`, WIDTH=8: 8'hA5 with parity 0 -> `out_perr`=0. Same data with parity 1 -> `out_perr`=1. Each frame takes 9 beats.
- Continuous stream of four WIDTH=4 frames (4'h1, 4'h2, 4'h4, 4'h8) with `out_ready`=1 -> `out_valid` pulses every 4 cycles and `in_ready` stays 1 throughout.
